kbd_event_sched: RTL and testbench
==================================

KBD_EVENT_SCHED -- requirements
Module: kbd_event_sched

Interface
REQ-001 SHALL have parameter GAP, default 7000000, clocks between consecutive scripted event slots (GAP >= 4).
REQ-002 SHALL have parameter DEPTH, default 32, script RAM entries (power of two).
REQ-003 SHALL use a single clock and an asynchronous, active-high reset:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset    in  1  asynchronous, active-high reset.
REQ-004 SHALL have the remaining ports:
- ps2_strobe   in   1             one-cycle live key event from the PS/2 decoder.
- ps2_release  in   1             live event is a release.
- ps2_code     in   8             live scancode.
- script_we    in   1             script RAM write strobe.
- script_addr  in   log2(DEPTH)   write address.
- script_data  in   9             entry {release, code}.
- script_len   in   log2(DEPTH)+1 entries to play, sampled at start.
- script_start in   1             start playback pulse.
- ev_strobe    out  1             one-cycle merged event to the matrix decoder.
- ev_release   out  1             merged release flag.
- ev_code      out  8             merged scancode.
- busy         out  1             playback in progress.
- done         out  1             one-cycle pulse on normal completion.
- aborted      out  1             one-cycle pulse on abort.

Function
REQ-005 SHALL register all outputs; a live event SHALL appear on ev_* exactly 1 cycle after ps2_strobe, with identical release/code.
REQ-006 SHALL emit at most one ev_strobe per cycle; ev_release/ev_code SHALL hold their last value while ev_strobe=0.
REQ-007 SHALL use states IDLE, WAIT, FETCH, EMIT: IDLE->WAIT on script_start; WAIT->FETCH when the gap counter reaches GAP-1; FETCH->EMIT, with the RAM read registered; EMIT->WAIT on the next slot, or ->IDLE at the end.
REQ-008 SHALL emit the first scripted slot GAP cycles after the script_start cycle, and each following slot GAP cycles after the previous slot's actual emission cycle.
REQ-009 SHALL treat entry 9'h000 as a pause: it consumes a slot and produces no strobe.
REQ-010 SHALL treat entry 9'h1FF as an end marker. Reaching index script_len or an end marker SHALL pulse done in the slot cycle; busy SHALL drop the same cycle, with no strobe.
REQ-011 SHALL, for script_len=0, pulse done 1 cycle after script_start and emit nothing.
REQ-012 SHALL, when a live event and a scripted slot coincide, give the live event priority and emit the scripted entry the following cycle. The slot timing reference SHALL shift by one cycle; a second coincidence SHALL defer it again.
REQ-013 SHALL abort playback on a live press of ESC (release=0, code 8'h76) while busy:
- the ESC event is still forwarded per REQ-005;
- aborted pulses with it; busy drops with it;
- no further scripted events are emitted; done does not pulse.
REQ-014 SHALL ignore script_start while busy and ignore script_we while busy; RAM contents are unchanged.
REQ-015 SHALL wrap the read index modulo DEPTH only if script_len=DEPTH; the index SHALL never exceed script_len.
REQ-016 SHALL drop live events whose code is 8'hE0 or 8'hF0 (prefixes never reach here).

Reset
REQ-017 SHALL on reset assertion immediately force ev_strobe=0, ev_release=0, ev_code=0, busy=0, done=0, aborted=0, state=IDLE and the counters to 0.
REQ-018 SHALL NOT reset script RAM contents; reset mid-playback SHALL end playback without done or aborted.
REQ-019 SHALL accept no events in the cycle reset deasserts; normal operation resumes the following cycle.

Structure
REQ-020 SHALL place the state enum, the constants PAUSE_ENTRY=9'h000, END_ENTRY=9'h1FF and ABORT_CODE=8'h76, and the 9-bit entry typedef in shared package kbd_pkg.
REQ-021 SHALL implement script storage as one sub-module, kbd_script_ram: DEPTH x 9, one write port, one registered read port, and no reset.

Verification
REQ-022 SHALL cover these directed scenarios, all with GAP=8:
- Live pass-through: ps2_strobe with {0,8'h1C} at cycle 10 -> ev_strobe with {0,8'h1C} at cycle 11, and nothing else.
- Script playback: entries {0,3B},{1,3B},000,{0,5A}, script_len=4, start at cycle 0 -> strobes at cycles 8, 16 and 32; done at cycle 40; busy high cycles 1-39.
- Collision: live event at the cycle of the second slot -> live event emitted first, scripted {1,3B} one cycle later, the next slot shifted by +1.
- Abort: ESC press during WAIT -> ESC forwarded, aborted pulse, busy=0, no further scripted events, done never pulses.
- End marker and len=0: 1FF at index 1 -> one event then done; script_len=0 -> done 1 cycle after start.
- Reset mid-EMIT, and script_start/script_we while busy -> outputs 0 immediately; RAM intact on replay; the start and write are ignored.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types, constants and helpers for the keyboard event scheduler.
package kbd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FETCH = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  typedef logic [8:0] entry_t;

  localparam entry_t     PAUSE_ENTRY = 9'h000;
  localparam entry_t     END_ENTRY   = 9'h1FF;
  localparam logic [7:0] ABORT_CODE  = 8'h76;

  function automatic logic is_prefix(input logic [7:0] code);
    return (code == 8'hE0) || (code == 8'hF0);
  endfunction

  function automatic logic is_abort(input logic rel, input logic [7:0] code);
    return !rel && (code == ABORT_CODE);
  endfunction

endpackage

// File: rtl/kbd_script_ram.sv
// Script storage: DEPTH x 9 bits, one write port, one registered read port.
// Contents are deliberately not reset so a script survives a reset.
module kbd_script_ram
  import kbd_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];
  entry_t rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/kbd_event_sched.sv
// Merges live PS/2 key events with scripted events replayed from a small RAM
// at a fixed slot spacing; live events always win and ESC aborts playback.
module kbd_event_sched
  import kbd_pkg::*;
#(
  parameter int GAP   = 7000000,
  parameter int DEPTH = 32
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     ps2_strobe,
  input  logic                     ps2_release,
  input  logic [7:0]               ps2_code,
  input  logic                     script_we,
  input  logic [$clog2(DEPTH)-1:0] script_addr,
  input  logic [8:0]               script_data,
  input  logic [$clog2(DEPTH):0]   script_len,
  input  logic                     script_start,
  output logic                     ev_strobe,
  output logic                     ev_release,
  output logic [7:0]               ev_code,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(GAP + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          ev_strobe_q, ev_strobe_d;
  logic          ev_release_q, ev_release_d;
  logic [7:0]    ev_code_q, ev_code_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          hold_q, hold_d;
  logic          live_v;
  logic          ram_we;
  entry_t        ram_rdata;

  assign live_v = ps2_strobe && !hold_q && !is_prefix(ps2_code);
  assign ram_we = script_we && !busy_q && !hold_q;

  kbd_script_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk_sys),
    .we    (ram_we),
    .waddr (script_addr),
    .wdata (script_data),
    .raddr (idx_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Next-state, slot timing and merged output selection
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    len_d        = len_q;
    ev_strobe_d  = 1'b0;
    ev_release_d = ev_release_q;
    ev_code_d    = ev_code_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    hold_d       = 1'b0;

    if (live_v) begin
      ev_strobe_d  = 1'b1;
      ev_release_d = ps2_release;
      ev_code_d    = ps2_code;
    end else begin
      ev_strobe_d  = 1'b0;
    end

    if (busy_q && live_v && is_abort(ps2_release, ps2_code)) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end else begin
      // cnt holds (cycles since slot reference + 2) so FETCH/EMIT land exactly on the slot
      case (state_q)
        S_IDLE: begin
          if (script_start && !hold_q) begin
            if (script_len == {(AW+1){1'b0}}) begin
              done_d = 1'b1;
            end else begin
              state_d = S_WAIT;
              busy_d  = 1'b1;
              idx_d   = {(AW+1){1'b0}};
              len_d   = script_len;
              cnt_d   = CW'(3);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == CW'(GAP - 1)) begin
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FETCH: begin
          state_d = S_EMIT;
        end
        S_EMIT: begin
          if ((idx_q == len_q) || (ram_rdata == END_ENTRY)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (ram_rdata == PAUSE_ENTRY) begin
            state_d = S_WAIT;
            idx_d   = idx_q + (AW+1)'(1);
            cnt_d   = CW'(2);
          end else if (live_v) begin
            state_d = S_EMIT;
          end else begin
            ev_strobe_d  = 1'b1;
            ev_release_d = ram_rdata[8];
            ev_code_d    = ram_rdata[7:0];
            state_d      = S_WAIT;
            idx_d        = idx_q + (AW+1)'(1);
            cnt_d        = CW'(2);
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; hold_q blocks inputs for the first cycle after reset
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CW{1'b0}};
      idx_q        <= {(AW+1){1'b0}};
      len_q        <= {(AW+1){1'b0}};
      ev_strobe_q  <= 1'b0;
      ev_release_q <= 1'b0;
      ev_code_q    <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      hold_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      ev_strobe_q  <= ev_strobe_d;
      ev_release_q <= ev_release_d;
      ev_code_q    <= ev_code_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      hold_q       <= hold_d;
    end
  end

  assign ev_strobe  = ev_strobe_q;
  assign ev_release = ev_release_q;
  assign ev_code    = ev_code_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_kbd_event_sched.sv
// Scoreboard bench for kbd_event_sched: a slot-arithmetic reference model
// predicts per-cycle outputs; a negedge monitor compares them to the DUT.
module tb_kbd_event_sched;

  localparam int GAP   = 8;
  localparam int DEPTH = 8;

  typedef struct packed {
    int         cyc;
    logic       strobe;
    logic       rel;
    logic [7:0] code;
    logic       done;
    logic       aborted;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       ps2_strobe, ps2_release;
  logic [7:0] ps2_code;
  logic       script_we;
  logic [2:0] script_addr;
  logic [8:0] script_data;
  logic [3:0] script_len;
  logic       script_start;
  logic       ev_strobe, ev_release, busy, done, aborted;
  logic [7:0] ev_code;

  kbd_event_sched #(.GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .reset        (rst),
    .ps2_strobe   (ps2_strobe),
    .ps2_release  (ps2_release),
    .ps2_code     (ps2_code),
    .script_we    (script_we),
    .script_addr  (script_addr),
    .script_data  (script_data),
    .script_len   (script_len),
    .script_start (script_start),
    .ev_strobe    (ev_strobe),
    .ev_release   (ev_release),
    .ev_code      (ev_code),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- reference model state ----------------
  exp_t       q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [8:0] mdl_mem [DEPTH];
  bit         playing = 1'b0;
  bit         blk = 1'b1;
  int         idx = 0;
  int         len = 0;
  int         next_slot = 0;
  logic       mdl_busy = 1'b0;
  logic       mdl_rel = 1'b0;
  logic [7:0] mdl_code = 8'h00;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Reference: slots are absolute cycle numbers; outputs predicted for cycle cyc+1
  always @(posedge clk_sys or posedge rst) begin : model
    exp_t       rec;
    logic       live;
    logic       esc;
    logic [8:0] ent;
    if (rst) begin
      q.delete();
      playing  = 1'b0;
      blk      = 1'b1;
      mdl_busy = 1'b0;
      mdl_rel  = 1'b0;
      mdl_code = 8'h00;
    end else begin
      rec = '0;
      rec.cyc = cyc + 1;
      if (blk) begin
        blk = 1'b0;
      end else begin
        live = ps2_strobe && ps2_code != 8'hE0 && ps2_code != 8'hF0;
        esc  = live && !ps2_release && ps2_code == 8'h76;
        if (live) begin
          rec.strobe = 1'b1;
          rec.rel    = ps2_release;
          rec.code   = ps2_code;
        end
        if (playing) begin
          if (esc) begin
            rec.aborted = 1'b1;
            playing = 1'b0;
          end else if (cyc + 1 == next_slot) begin
            ent = mdl_mem[idx % DEPTH];
            if (idx == len || ent == 9'h1FF) begin
              rec.done = 1'b1;
              playing = 1'b0;
            end else if (ent == 9'h000) begin
              idx++;
              next_slot = cyc + 1 + GAP;
            end else if (live) begin
              next_slot = next_slot + 1;
            end else begin
              rec.strobe = 1'b1;
              rec.rel    = ent[8];
              rec.code   = ent[7:0];
              idx++;
              next_slot = cyc + 1 + GAP;
            end
          end
        end else begin
          if (script_we) mdl_mem[script_addr] = script_data;
          if (script_start) begin
            if (script_len == 4'd0) begin
              rec.done = 1'b1;
            end else begin
              playing   = 1'b1;
              idx       = 0;
              len       = int'(script_len);
              next_slot = cyc + GAP;
            end
          end
        end
      end
      if (rec.strobe) begin
        mdl_rel  = rec.rel;
        mdl_code = rec.code;
      end
      mdl_busy = playing;
      if (rec.strobe || rec.done || rec.aborted) q.push_back(rec);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the record due this cycle and checks every output
  always @(negedge clk_sys) begin : monitor
    exp_t e;
    e = '0;
    if (q.size() != 0 && q[0].cyc == cyc) e = q.pop_front();
    if (rst) begin
      chk("rst_ev_strobe", ev_strobe, 1'b0);
      chk("rst_ev_code", {ev_release, ev_code}, 9'h000);
      chk("rst_busy_done_abort", {busy, done, aborted}, 3'b000);
    end else begin
      chk("ev_strobe", ev_strobe, e.strobe);
      chk("ev_release", ev_release, mdl_rel);
      chk("ev_code", ev_code, mdl_code);
      chk("done", done, e.done);
      chk("aborted", aborted, e.aborted);
      chk("busy", busy, mdl_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
    ps2_strobe   = 1'b0;
    script_we    = 1'b0;
    script_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input logic [8:0] d);
    script_addr = 3'(a);
    script_data = d;
    script_we   = 1'b1;
    step();
  endtask

  task automatic live_ev(input logic r, input logic [7:0] c);
    ps2_release = r;
    ps2_code    = c;
    ps2_strobe  = 1'b1;
    step();
  endtask

  task automatic start(input int n);
    script_len   = 4'(n);
    script_start = 1'b1;
    step();
  endtask

  initial begin
    int r;
    int k;
    rst = 1'b1;
    ps2_strobe = 1'b0; ps2_release = 1'b0; ps2_code = 8'h00;
    script_we = 1'b0; script_addr = 3'd0; script_data = 9'h000;
    script_len = 4'd0; script_start = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;
    idle(2);
    for (int i = 0; i < DEPTH; i++) wr(i, 9'h000);
    wr(0, 9'h03B); wr(1, 9'h13B); wr(2, 9'h000); wr(3, 9'h05A);

    idle(5); live_ev(1'b0, 8'h1C); idle(5);             // live pass-through
    start(4); idle(45);                                  // plain playback
    start(4); idle(14); live_ev(1'b0, 8'h29);            // collision on slot 2
    live_ev(1'b1, 8'h29); idle(45);                      // second collision defers again
    start(4); idle(3); live_ev(1'b0, 8'h76); idle(45);   // ESC press aborts
    start(4); idle(3); live_ev(1'b1, 8'h76); idle(45);   // ESC release does not
    live_ev(1'b0, 8'hE0); live_ev(1'b1, 8'hF0); idle(2); // prefixes dropped
    wr(1, 9'h1FF); start(4); idle(25);                   // end marker at index 1
    start(0); idle(3);                                   // zero-length script
    wr(1, 9'h13B);

    start(4); idle(6);                                   // now in the EMIT cycle
    rst = 1'b1; step(); step();
    rst = 1'b0;
    live_ev(1'b0, 8'h33);                                // ignored: first cycle after reset
    idle(3);
    start(4); idle(3); wr(0, 9'h0AA); start(1); idle(45); // ignored while busy
    start(4); idle(45);                                  // replay shows RAM intact
    for (int i = 4; i < DEPTH; i++) wr(i, 9'(9'h020 + i));
    start(DEPTH); idle(GAP * (DEPTH + 2));               // full-depth script

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 7) begin
        k = $urandom_range(0, 9);
        ps2_release = 1'($urandom_range(0, 1));
        ps2_code    = (k == 0) ? 8'h76 : (k == 1) ? 8'hE0 : (k == 2) ? 8'hF0 : 8'($urandom);
        ps2_strobe  = 1'b1;
      end else if (r < 11) begin
        k = $urandom_range(0, 7);
        script_addr = 3'($urandom);
        script_data = (k == 0) ? 9'h000 : (k == 1) ? 9'h1FF : 9'($urandom);
        script_we   = 1'b1;
      end else if (r < 14) begin
        script_len   = 4'($urandom_range(0, DEPTH));
        script_start = 1'b1;
      end
      step();
    end

    idle(20);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
